// File: rtl/aes_decrypt_ctrl.sv
// aes_decrypt_ctrl
// ----------------
// Round sequencer for an iterative AES decryption datapath. It checks that
// round keys exist and starts key expansion when they do not. It then steps
// the shared inverse-round datapath through the initial AddRoundKey, NR-1
// full inverse rounds and the final round, and pulses done when finished.
// The block holds no data of its own.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   request one block decryption (sampled in IDLE only)
//   new_key    in   sampled with start; 1 forces key expansion to rerun
//   key_ready  in   key-expansion unit finished (sampled in KEYGEN only)
//   key_start  out  one-cycle pulse that launches key expansion
//   rk_addr    out  round key index the datapath uses this cycle
//   dp_load    out  datapath captures input block XOR round key rk_addr
//   dp_en      out  datapath state register takes a round result
//   dp_mode    out  00 AddRoundKey, 01 full inverse round, 10 final round
//   busy       out  a block is in progress
//   done       out  one-cycle pulse, datapath output valid
//
// Every output is taken straight from a flop. Each output flop is loaded
// with the value decoded from the next state and next counter, so no output
// depends combinationally on an input. The async reset clears all outputs
// at once.

module aes_decrypt_ctrl #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       new_key,
    input  logic       key_ready,
    output logic       key_start,
    output logic [3:0] rk_addr,
    output logic       dp_load,
    output logic       dp_en,
    output logic [1:0] dp_mode,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYGEN = 3'd1,
        S_INIT   = 3'd2,
        S_ROUND  = 3'd3,
        S_FINAL  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       keys_valid, keys_valid_nxt;
    logic       kg_first, kg_first_nxt;

    logic       key_start_nxt;
    logic [3:0] rk_addr_nxt;
    logic       dp_load_nxt;
    logic       dp_en_nxt;
    logic [1:0] dp_mode_nxt;
    logic       busy_nxt;
    logic       done_nxt;

    // State, round counter, key flag and all output flops. kg_first is set
    // only on the transition into KEYGEN, so key_start lasts exactly one
    // cycle even if KEYGEN waits a long time for key_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            keys_valid <= 1'b0;
            kg_first   <= 1'b0;
            key_start  <= 1'b0;
            rk_addr    <= 4'd0;
            dp_load    <= 1'b0;
            dp_en      <= 1'b0;
            dp_mode    <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            keys_valid <= keys_valid_nxt;
            kg_first   <= kg_first_nxt;
            key_start  <= key_start_nxt;
            rk_addr    <= rk_addr_nxt;
            dp_load    <= dp_load_nxt;
            dp_en      <= dp_en_nxt;
            dp_mode    <= dp_mode_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    // Next-state logic. The counter is loaded with NR on the way into INIT.
    // It decrements once per INIT/ROUND cycle, so ROUND issues NR-1 down to
    // 1 and FINAL sees 0. The counter never wraps.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        keys_valid_nxt = keys_valid;
        kg_first_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nxt = 4'd0;
                if (start) begin
                    if (new_key || !keys_valid) begin
                        state_nxt      = S_KEYGEN;
                        keys_valid_nxt = 1'b0;
                        kg_first_nxt   = 1'b1;
                    end else begin
                        state_nxt = S_INIT;
                        cnt_nxt   = NR_L;
                    end
                end
            end
            S_KEYGEN: begin
                if (key_ready) begin
                    keys_valid_nxt = 1'b1;
                    state_nxt      = S_INIT;
                    cnt_nxt        = NR_L;
                end
            end
            S_INIT: begin
                state_nxt = S_ROUND;
                cnt_nxt   = cnt - 4'd1;
            end
            S_ROUND: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = S_FINAL;
                end
            end
            S_FINAL: begin
                state_nxt = S_DONE;
                cnt_nxt   = 4'd0;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Output decode of the next state. The result is registered above, so
    // each output lines up with the cycle its state is active.
    always_comb begin
        key_start_nxt = 1'b0;
        rk_addr_nxt   = 4'd0;
        dp_load_nxt   = 1'b0;
        dp_en_nxt     = 1'b0;
        dp_mode_nxt   = 2'b00;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;

        case (state_nxt)
            S_KEYGEN: begin
                busy_nxt      = 1'b1;
                key_start_nxt = kg_first_nxt;
            end
            S_INIT: begin
                busy_nxt    = 1'b1;
                dp_load_nxt = 1'b1;
                rk_addr_nxt = cnt_nxt;
            end
            S_ROUND: begin
                busy_nxt    = 1'b1;
                dp_en_nxt   = 1'b1;
                dp_mode_nxt = 2'b01;
                rk_addr_nxt = cnt_nxt;
            end
            S_FINAL: begin
                busy_nxt    = 1'b1;
                dp_en_nxt   = 1'b1;
                dp_mode_nxt = 2'b10;
            end
            S_DONE: begin
                done_nxt = 1'b1;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// tb_aes_decrypt_ctrl
// -------------------
// Directed testbench for aes_decrypt_ctrl. Three instances (NR = 10, 12, 14)
// share one set of inputs, so the round-count sweep runs in parallel with the
// main NR=10 checks. Expected values are hand-derived cycle numbers counted
// from the edge that accepts start.

module tb_aes_decrypt_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic new_key;
    logic key_ready;

    logic       o10_key_start, o12_key_start, o14_key_start;
    logic [3:0] o10_rk_addr, o12_rk_addr, o14_rk_addr;
    logic       o10_dp_load, o12_dp_load, o14_dp_load;
    logic       o10_dp_en, o12_dp_en, o14_dp_en;
    logic [1:0] o10_dp_mode, o12_dp_mode, o14_dp_mode;
    logic       o10_busy, o12_busy, o14_busy;
    logic       o10_done, o12_done, o14_done;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    aes_decrypt_ctrl #(.NR(10)) dut10 (
        .clk(clk), .reset(reset), .start(start), .new_key(new_key),
        .key_ready(key_ready), .key_start(o10_key_start), .rk_addr(o10_rk_addr),
        .dp_load(o10_dp_load), .dp_en(o10_dp_en), .dp_mode(o10_dp_mode),
        .busy(o10_busy), .done(o10_done)
    );

    aes_decrypt_ctrl #(.NR(12)) dut12 (
        .clk(clk), .reset(reset), .start(start), .new_key(new_key),
        .key_ready(key_ready), .key_start(o12_key_start), .rk_addr(o12_rk_addr),
        .dp_load(o12_dp_load), .dp_en(o12_dp_en), .dp_mode(o12_dp_mode),
        .busy(o12_busy), .done(o12_done)
    );

    aes_decrypt_ctrl #(.NR(14)) dut14 (
        .clk(clk), .reset(reset), .start(start), .new_key(new_key),
        .key_ready(key_ready), .key_start(o14_key_start), .rk_addr(o14_rk_addr),
        .dp_load(o14_dp_load), .dp_en(o14_dp_en), .dp_mode(o14_dp_mode),
        .busy(o14_busy), .done(o14_done)
    );

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the inputs, then let one active edge sample them.
    task automatic applyStimulus(input logic s, input logic nk, input logic kr);
        start     = s;
        new_key   = nk;
        key_ready = kr;
        tick();
    endtask

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vecCount++;
        if (observed != expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Check that every NR=10 output is zero.
    task automatic checkIdle10(input string tag);
        checkOutput({tag, "_key_start"}, int'(o10_key_start), 0);
        checkOutput({tag, "_rk_addr"},   int'(o10_rk_addr),   0);
        checkOutput({tag, "_dp_load"},   int'(o10_dp_load),   0);
        checkOutput({tag, "_dp_en"},     int'(o10_dp_en),     0);
        checkOutput({tag, "_dp_mode"},   int'(o10_dp_mode),   0);
        checkOutput({tag, "_busy"},      int'(o10_busy),      0);
        checkOutput({tag, "_done"},      int'(o10_done),      0);
    endtask

    initial begin
        int d10, d12, d14, n10, n12, n14, loads, dones, rounds14;
        int expRk, expMode;
        bit found;

        reset     = 1'b1;
        start     = 1'b0;
        new_key   = 1'b0;
        key_ready = 1'b0;
        $display("[TB] aes_decrypt_ctrl directed test");

        // ---- reset state ----
        tick();
        tick();
        checkIdle10("rst");
        checkOutput("rst_busy14", int'(o14_busy), 0);
        reset = 1'b0;
        tick();

        // ---- first start after reset takes KEYGEN even with new_key=0 ----
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("kg_key_start_e1", int'(o10_key_start), 1);
        checkOutput("kg_busy_e1",      int'(o10_busy),      1);
        checkOutput("kg_load_e1",      int'(o10_dp_load),   0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("kg_key_start_e2", int'(o10_key_start), 0);
        checkOutput("kg_busy_e2",      int'(o10_busy),      1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("kg_wait_busy[%0d]", i), int'(o10_busy), 1);
            checkOutput($sformatf("kg_wait_ks[%0d]", i), int'(o10_key_start), 0);
        end
        // key_ready seen at edge K; INIT in K+1.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("kg_init_load", int'(o10_dp_load), 1);
        checkOutput("kg_init_rk",   int'(o10_rk_addr), 10);
        checkOutput("kg_init_rk14", int'(o14_rk_addr), 14);
        d10 = -1; d12 = -1; d14 = -1; n10 = 0; n12 = 0; n14 = 0;
        for (int k = 2; k <= 20; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (o10_done) begin n10++; if (d10 < 0) d10 = k; end
            if (o12_done) begin n12++; if (d12 < 0) d12 = k; end
            if (o14_done) begin n14++; if (d14 < 0) d14 = k; end
        end
        checkOutput("kg_done_at_10", d10, 12);
        checkOutput("kg_done_at_12", d12, 14);
        checkOutput("kg_done_at_14", d14, 16);
        checkOutput("kg_done_cnt10", n10, 1);
        checkOutput("kg_done_cnt14", n14, 1);

        // ---- cached-key path: full per-cycle sequence for NR=10 ----
        applyStimulus(1'b1, 1'b0, 1'b0);
        d12 = -1; d14 = -1; rounds14 = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 1)       begin expRk = 10;     expMode = 0; end
            else if (k <= 10) begin expRk = 11 - k; expMode = 1; end
            else if (k == 11) begin expRk = 0;      expMode = 2; end
            else              begin expRk = 0;      expMode = 0; end
            checkOutput($sformatf("seq_rk[%0d]", k),   int'(o10_rk_addr), expRk);
            checkOutput($sformatf("seq_mode[%0d]", k), int'(o10_dp_mode), expMode);
            checkOutput($sformatf("seq_load[%0d]", k), int'(o10_dp_load), (k == 1) ? 1 : 0);
            checkOutput($sformatf("seq_en[%0d]", k),   int'(o10_dp_en),   (k >= 2 && k <= 11) ? 1 : 0);
            checkOutput($sformatf("seq_busy[%0d]", k), int'(o10_busy),    (k <= 11) ? 1 : 0);
            checkOutput($sformatf("seq_done[%0d]", k), int'(o10_done),    (k == 12) ? 1 : 0);
            checkOutput($sformatf("seq_ks[%0d]", k),   int'(o10_key_start), 0);
            if (k == 1) checkOutput("seq_rk14_first", int'(o14_rk_addr), 14);
            if (o14_dp_en && o14_dp_mode == 2'b01) rounds14++;
            if (o12_done && d12 < 0) d12 = k;
            if (o14_done && d14 < 0) d14 = k;
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("seq_done_at_12", d12, 14);
        checkOutput("seq_done_at_14", d14, 16);
        checkOutput("seq_rounds14", rounds14, 13);
        for (int i = 0; i < 4; i++) tick();

        // ---- start held high: one operation per IDLE visit ----
        loads = 0; dones = 0;
        for (int k = 1; k <= 27; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (o10_dp_load) loads++;
            if (o10_done) dones++;
            if (k == 13) begin
                checkOutput("hold_idle_busy", int'(o10_busy), 0);
                checkOutput("hold_idle_load", int'(o10_dp_load), 0);
            end
            if (k == 14) checkOutput("hold_reinit_load", int'(o10_dp_load), 1);
            if (k == 12) checkOutput("hold_done", int'(o10_done), 1);
        end
        checkOutput("hold_load_count", loads, 3);
        checkOutput("hold_done_count", dones, 2);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        // ---- async reset mid-ROUND at rk_addr=5 ----
        applyStimulus(1'b1, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (o10_dp_en && o10_rk_addr == 4'd5) found = 1'b1;
            else applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("mid_found_rk5", int'(found), 1);
        #2 reset = 1'b1;
        #1;
        checkIdle10("mid_rst");
        checkOutput("mid_rst_busy14", int'(o14_busy), 0);
        tick();
        reset = 1'b0;
        tick();
        // key_ready high already at the first KEYGEN edge: one-cycle KEYGEN.
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("post_rst_key_start", int'(o10_key_start), 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("post_rst_init", int'(o10_dp_load), 1);
        checkOutput("post_rst_ks_off", int'(o10_key_start), 0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        // ---- new_key=1 with valid keys reruns expansion ----
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("newkey_key_start", int'(o10_key_start), 1);
        checkOutput("newkey_no_load", int'(o10_dp_load), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("newkey_init", int'(o10_dp_load), 1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkIdle10("end");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    // Watchdog: keeps the run bounded if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
